// File: rtl/stream_pkg.sv
// Shared stream-side types: output beat, controller status and the receive FSM states.
// Also used by the tx side, so the field widths are fixed here rather than per instance.
package stream_pkg;

    localparam int STREAM_DATA_W  = 32;
    localparam int STREAM_LEVEL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP
    } rx_state_e;

    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic [STREAM_DATA_W-1:0] data;
    } STREAM_BEAT;

    typedef struct packed {
        logic                      valid;
        logic                      frame_done;
        logic                      len_err;
        logic                      drop;
        logic [STREAM_LEVEL_W-1:0] level;
    } RX_STATUS;

endpackage

// File: rtl/stream_slave_fifo_if.sv
// AXI4-Stream beat bundle; the sink owns tready, the source owns everything else.
interface stream_slave_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tstrb, tlast, tvalid, input tready);
    modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered pointers and fill level; read data is mem[rd_ptr], no bypass.
// The caller must not push when full nor pop when empty.
module stream_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
endmodule

// File: rtl/stream_slave_fifo.sv
// FFT input sink: TSTRB byte masking, frame-length FSM and output register around stream_fifo.
// Accept-to-data_out latency 2 cycles minimum; tready is registered and low only while the FIFO is full.
module stream_slave_fifo
    import stream_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = STREAM_DATA_W,
    parameter int FIFO_DEPTH           = 16,
    parameter int FRAME_LEN            = 64
) (
    input  logic               S_AXIS_ACLK,
    input  logic               S_AXIS_ARESETN,
    stream_slave_fifo_if.slave s_axis,
    input  logic               is_ready,
    output STREAM_BEAT         data_out,
    output RX_STATUS           rx_to_cont
);
    localparam int LEN_W  = $clog2(FRAME_LEN + 1);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int FW     = C_S_AXIS_TDATA_WIDTH + 1;

    rx_state_e                 state, state_nxt;
    logic [LEN_W-1:0]          beat_cnt, beat_cnt_nxt, beat_cnt_inc;
    logic                      acc, push, push_last, len_err_nxt, drop_nxt;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] masked;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]             fifo_rd_dat;
    logic [LVL_W-1:0]          fifo_level, level_nxt;
    logic                      tready_q, len_err_q, drop_q;
    STREAM_BEAT                out_q;

    assign acc           = s_axis.tvalid && tready_q;
    assign s_axis.tready = tready_q;
    assign beat_cnt_inc  = beat_cnt + LEN_W'(1);

    always_comb begin
        masked = '0;
        for (int i = 0; i < STRB_W; i++) begin
            masked[8*i +: 8] = s_axis.tstrb[i] ? s_axis.tdata[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        push         = 1'b0;
        push_last    = 1'b0;
        len_err_nxt  = 1'b0;
        drop_nxt     = 1'b0;
        unique case (state)
            IDLE: if (acc) begin
                push = 1'b1;
                if (s_axis.tlast) begin
                    // A one-beat frame is always short (FRAME_LEN >= 2).
                    push_last    = 1'b1;
                    len_err_nxt  = 1'b1;
                    beat_cnt_nxt = '0;
                end else begin
                    beat_cnt_nxt = LEN_W'(1);
                    state_nxt    = ACTIVE;
                end
            end
            ACTIVE: if (acc) begin
                push = 1'b1;
                if (s_axis.tlast) begin
                    push_last    = 1'b1;
                    len_err_nxt  = (beat_cnt_inc != LEN_W'(FRAME_LEN));
                    beat_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else if (beat_cnt_inc == LEN_W'(FRAME_LEN)) begin
                    // Close the frame for the core and discard the overrun up to TLAST.
                    push_last    = 1'b1;
                    len_err_nxt  = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = DROP;
                end else begin
                    beat_cnt_nxt = beat_cnt_inc;
                end
            end
            DROP: if (acc) begin
                drop_nxt = 1'b1;
                if (s_axis.tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign fifo_push = push && !fifo_full;
    assign fifo_pop  = is_ready && !fifo_empty;
    assign level_nxt = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (S_AXIS_ACLK),
        .rst_n    (S_AXIS_ARESETN),
        .push     (fifo_push),
        .push_dat ({push_last, masked}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // tready looks one cycle ahead so it drops in the same edge the last free slot fills.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            tready_q  <= 1'b0;
            len_err_q <= 1'b0;
            drop_q    <= 1'b0;
            out_q     <= '0;
        end else begin
            tready_q  <= (level_nxt != LVL_W'(FIFO_DEPTH));
            len_err_q <= len_err_nxt;
            drop_q    <= drop_nxt;
            if (fifo_pop) begin
                out_q.valid <= 1'b1;
                out_q.last  <= fifo_rd_dat[FW-1];
                out_q.data  <= STREAM_DATA_W'(fifo_rd_dat[C_S_AXIS_TDATA_WIDTH-1:0]);
            end else begin
                out_q <= '0;
            end
        end
    end

    assign data_out   = out_q;
    assign rx_to_cont = '{valid:      out_q.valid,
                          frame_done: out_q.valid && out_q.last,
                          len_err:    len_err_q,
                          drop:       drop_q,
                          level:      STREAM_LEVEL_W'(fifo_level)};
endmodule
